// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV32 pipeline: load-use/redirect/memory-wait stalls and flushes,
// E-stage forwarding, and a memory-wait watchdog. Define HAZARD_PERF_CNT_EN for stall/flush counters.
module hazard_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       Rs1_D,
   input  logic [4:0]       Rs2_D,
   input  logic [4:0]       Rs1_E,
   input  logic [4:0]       Rs2_E,
   input  logic [4:0]       Rd_E,
   input  logic [1:0]       ResultSrc_E,
   input  logic             PCSrc_E,
   input  logic [4:0]       Rd_M,
   input  logic             RegWrite_M,
   input  logic             MemAccess_M,
   input  logic             MemReady,
   input  logic [4:0]       Rd_W,
   input  logic             RegWrite_W,
   output logic             StallF,
   output logic             StallD,
   output logic             StallE,
   output logic             StallM,
   output logic             FlushD,
   output logic             FlushE,
   output logic             FlushW,
   output logic [1:0]       ForwardAE,
   output logic [1:0]       ForwardBE,
   output logic             MemTimeout,
   output logic [CNT_W-1:0] StallCnt,
   output logic [CNT_W-1:0] FlushCnt
);

   localparam int unsigned      WaitW   = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WaitW-1:0] WaitMax = WaitW'(MEM_TIMEOUT);

   typedef enum logic [0:0] {StRun, StWait} state_e;

   state_e           state_q, state_d;
   logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
   logic             timeout_q, timeout_d;

   logic mem_stall;
   logic lw_stall;

   assign mem_stall = MemAccess_M & ~MemReady;
   assign lw_stall  = (ResultSrc_E == 2'b01) && (Rd_E != 5'd0) &&
                      ((Rs1_D == Rd_E) || (Rs2_D == Rd_E));

   // M has priority over W; x0 is never forwarded.
   function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
      logic [1:0] sel;
      sel = 2'b00;
      if (RegWrite_M && (Rd_M != 5'd0) && (Rd_M == rs)) begin
         sel = 2'b10;
      end else if (RegWrite_W && (Rd_W != 5'd0) && (Rd_W == rs)) begin
         sel = 2'b01;
      end
      return sel;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StRun;
         wait_cnt_q <= '0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         timeout_q  <= timeout_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = '0;
      unique case (state_q)
         StRun: begin
            if (mem_stall) begin
               state_d    = StWait;
               wait_cnt_d = WaitW'(1);
            end
         end
         StWait: begin
            if (mem_stall) begin
               wait_cnt_d = (wait_cnt_q == WaitMax) ? wait_cnt_q : wait_cnt_q + WaitW'(1);
            end else begin
               state_d = StRun;
            end
         end
      endcase
      // Sticky: only rst clears the watchdog flag.
      timeout_d = timeout_q | (wait_cnt_d == WaitMax);
   end

   always_comb begin
      StallF    = lw_stall | mem_stall;
      StallD    = lw_stall | mem_stall;
      StallE    = mem_stall;
      StallM    = mem_stall;
      FlushW    = mem_stall;
      FlushE    = (lw_stall | PCSrc_E) & ~mem_stall;
      FlushD    = PCSrc_E & ~mem_stall;
      ForwardAE = fwd_sel(Rs1_E);
      ForwardBE = fwd_sel(Rs2_E);
      if (rst) begin
         StallF    = 1'b0;
         StallD    = 1'b0;
         StallE    = 1'b0;
         StallM    = 1'b0;
         FlushW    = 1'b0;
         FlushE    = 1'b1;
         FlushD    = 1'b1;
         ForwardAE = 2'b00;
         ForwardBE = 2'b00;
      end
   end

   assign MemTimeout = timeout_q;

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] flush_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (StallF) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         if (FlushE) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
   end

   assign StallCnt = stall_cnt_q;
   assign FlushCnt = flush_cnt_q;
`else
   assign StallCnt = '0;
   assign FlushCnt = '0;
`endif

endmodule
